// File: rtl/bus_term_pkg.sv
// Shared definitions for the bus terminal endpoint: ID field width, default
// broadcast address and the destination-ID extraction helper.
package bus_term_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;
    localparam int PKT_MAX = 256;

    // Packets are zero-extended to PKT_MAX so one helper serves any packet width.
    function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX-1:0] pkt,
                                                input int unsigned pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage

// File: rtl/bus_terminal_endpoint_fifo.sv
// Show-ahead synchronous FIFO. Read and write in the same cycle are both
// accepted when full. The head reads 0 while the FIFO is empty.
module term_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A write into a full FIFO is only safe when the head leaves on the same edge.
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/bus_terminal_endpoint.sv
// Device-side bus terminal: TX queue toward the bus, address-filtered RX
// queue toward the host, with drop/overflow counters and a pop-error pulse.
module bus_terminal_endpoint
    import bus_term_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'h00,
    parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic [7:0]         rx_drop_cnt,
    output logic [7:0]         rx_ovf_cnt,
    output logic               pop_err
);
    logic            tx_empty;
    logic            rx_full;
    logic            rx_empty;
    logic            accept;
    logic [ID_W-1:0] push_id;
    logic [7:0]      drop_cnt_reg;
    logic [7:0]      ovf_cnt_reg;
    logic            pop_err_reg;

    term_sync_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
        .clk     (clk),
        .srst    (reset),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (pop),
        .full    (tx_full),
        .empty   (tx_empty),
        .head    (D_pop)
    );

    assign push_id = dest_id(PKT_MAX'(D_push), pckg_sz);
    assign accept  = push && ((push_id == id) || (push_id == broadcast));

    term_sync_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
        .clk     (clk),
        .srst    (reset),
        .wr      (accept),
        .wr_data (D_push),
        .rd      (rx_rd),
        .full    (rx_full),
        .empty   (rx_empty),
        .head    (rx_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= '0;
            ovf_cnt_reg  <= '0;
            pop_err_reg  <= 1'b0;
        end else begin
            pop_err_reg <= pop && tx_empty;
            if (push && !accept && drop_cnt_reg != 8'hFF)
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            // A full RX FIFO still takes the packet if the host reads on the same edge.
            if (accept && rx_full && !rx_rd && ovf_cnt_reg != 8'hFF)
                ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
        end
    end

    assign pndng       = !tx_empty;
    assign rx_valid    = !rx_empty;
    assign rx_drop_cnt = drop_cnt_reg;
    assign rx_ovf_cnt  = ovf_cnt_reg;
    assign pop_err     = pop_err_reg;

endmodule

// File: tb/tb_bus_terminal_endpoint.sv
// Directed bench for bus_terminal_endpoint (id=3, depth=8, 16-bit packets).
module tb_bus_terminal_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_rd;
    logic [7:0]  rx_drop_cnt;
    logic [7:0]  rx_ovf_cnt;
    logic        pop_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_terminal_endpoint #(
        .pckg_sz(16), .depth(8), .id(8'h03), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
        .rx_drop_cnt(rx_drop_cnt), .rx_ovf_cnt(rx_ovf_cnt),
        .pop_err(pop_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pndng"},    32'(pndng),       32'd0);
        check({tag, "_tx_full"},  32'(tx_full),     32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid),    32'd0);
        check({tag, "_D_pop"},    32'(D_pop),       32'd0);
        check({tag, "_rx_data"},  32'(rx_data),     32'd0);
        check({tag, "_drop"},     32'(rx_drop_cnt), 32'd0);
        check({tag, "_ovf"},      32'(rx_ovf_cnt),  32'd0);
        check({tag, "_pop_err"},  32'(pop_err),     32'd0);
    endtask

    logic [15:0] tx_vec [3];

    initial begin
        reset = 1'b1; tx_wr = 1'b0; tx_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rx_rd = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_reset_state("reset");

        // 1: three writes, then three pops in order
        tx_vec[0] = 16'hAA01; tx_vec[1] = 16'hAA02; tx_vec[2] = 16'hAA03;
        tx_wr = 1'b1; tx_data = tx_vec[0];
        tick();
        check("t1_pndng_after_first", 32'(pndng), 32'd1);
        check("t1_head_after_first", 32'(D_pop), 32'hAA01);
        tx_data = tx_vec[1]; tick();
        tx_data = tx_vec[2]; tick();
        tx_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_D_pop_%0d", i), 32'(D_pop), 32'(tx_vec[i]));
            pop = 1'b1; tick(); pop = 1'b0;
        end
        check("t1_pndng_empty", 32'(pndng), 32'd0);
        check("t1_D_pop_empty", 32'(D_pop), 32'd0);
        check("t1_no_pop_err", 32'(pop_err), 32'd0);

        // 2: address filter
        push = 1'b1;
        D_push = 16'h03C5; tick();
        D_push = 16'hFF11; tick();
        D_push = 16'h0722; tick();
        push = 1'b0;
        check("t2_rx_valid", 32'(rx_valid), 32'd1);
        check("t2_rx_data0", 32'(rx_data), 32'h03C5);
        check("t2_drop", 32'(rx_drop_cnt), 32'd1);
        rx_rd = 1'b1; tick();
        check("t2_rx_data1", 32'(rx_data), 32'hFF11);
        tick(); rx_rd = 1'b0;
        check("t2_rx_valid_empty", 32'(rx_valid), 32'd0);
        check("t2_rx_data_empty", 32'(rx_data), 32'd0);
        check("t2_ovf", 32'(rx_ovf_cnt), 32'd0);

        // 3: TX full handling
        tx_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 16'h1000 + 16'(i);
            tick();
        end
        check("t3_full", 32'(tx_full), 32'd1);
        tx_data = 16'h1008; tick();
        check("t3_full_after_drop", 32'(tx_full), 32'd1);
        check("t3_head_after_drop", 32'(D_pop), 32'h1000);
        tx_data = 16'h1009; pop = 1'b1; tick();
        tx_wr = 1'b0; pop = 1'b0;
        check("t3_full_after_wr_pop", 32'(tx_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_drain_%0d", i), 32'(D_pop),
                  (i < 7) ? 32'h1001 + 32'(i) : 32'h1009);
            pop = 1'b1; tick(); pop = 1'b0;
        end
        check("t3_pndng_drained", 32'(pndng), 32'd0);

        // 4: RX full, overflow saturation, full+rx_rd store
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            D_push = 16'h0300 + 16'(i);
            tick();
        end
        check("t4_ovf_before", 32'(rx_ovf_cnt), 32'd0);
        D_push = 16'h03EE;
        for (int i = 0; i < 300; i++) tick();
        check("t4_ovf_sat", 32'(rx_ovf_cnt), 32'd255);
        check("t4_drop_unchanged", 32'(rx_drop_cnt), 32'd1);
        check("t4_head_intact", 32'(rx_data), 32'h0300);
        D_push = 16'h03AB; rx_rd = 1'b1; tick();
        push = 1'b0; rx_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_drain_%0d", i), 32'(rx_data),
                  (i < 7) ? 32'h0301 + 32'(i) : 32'h03AB);
            rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        end
        check("t4_rx_empty", 32'(rx_valid), 32'd0);

        // 5: pop while empty
        pop = 1'b1; tick(); pop = 1'b0;
        check("t5_pop_err_pulse", 32'(pop_err), 32'd1);
        check("t5_D_pop_zero", 32'(D_pop), 32'd0);
        check("t5_pndng_zero", 32'(pndng), 32'd0);
        tick();
        check("t5_pop_err_cleared", 32'(pop_err), 32'd0);
        tx_wr = 1'b1; tx_data = 16'h5555; pop = 1'b1; tick();
        tx_wr = 1'b0; pop = 1'b0;
        check("t5_err_with_wr", 32'(pop_err), 32'd1);
        check("t5_wr_accepted", 32'(D_pop), 32'h5555);
        pop = 1'b1; tick(); pop = 1'b0;
        check("t5_popped", 32'(pndng), 32'd0);

        // 6: reset dominates with both FIFOs half full
        push = 1'b1; tx_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 16'h2000 + 16'(i);
            D_push = 16'h0350 + 16'(i);
            tick();
        end
        D_push = 16'h0999; tick();
        check("t6_pre_pndng", 32'(pndng), 32'd1);
        check("t6_pre_rx_valid", 32'(rx_valid), 32'd1);
        check("t6_pre_drop", 32'(rx_drop_cnt), 32'd2);
        tx_data = 16'h2FFF; D_push = 16'h03FF; pop = 1'b1; rx_rd = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; push = 1'b0; tx_wr = 1'b0; pop = 1'b0; rx_rd = 1'b0;
        check_reset_state("t6_after_reset");
        tick();
        check("t6_nothing_tx", 32'(pndng), 32'd0);
        check("t6_nothing_rx", 32'(rx_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
